fanout_fork_ctrl: RTL and testbench
===================================

# fanout_fork_ctrl

Registered eager-fork controller that broadcasts one upstream token to up to NUM_OUT enabled downstream consumers, letting each consumer accept independently and freeing the input only once every enabled consumer has taken the token. It sits between a single producer stream and the fanout ports of a sparse-pipeline tile. It replaces the purely combinational "all consumers ready" gating with a one-entry buffer plus per-output served tracking, so one slow consumer never forces others to re-accept a token.

## Interface
- NUM_OUT, 6, number of downstream consumers (1..16)
- DATA_W, 17, token width (data plus control/done bit)
- CNT_W, 16, width of completed-token counter

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_en  in  NUM_OUT  per-consumer enable mask; sampled only at token load
- flush  in  1  synchronous clear of the buffered token
- in_valid  in  1  producer token valid
- in_data  in  DATA_W  producer token
- in_ready  out  1  buffer can accept a token this cycle
- out_valid  out  NUM_OUT  per-consumer valid
- out_data  out  DATA_W  buffered token, shared by all consumers
- out_ready  in  NUM_OUT  per-consumer ready
- token_cnt  out  CNT_W  count of fully delivered tokens, wraps modulo 2^CNT_W

## Operation
- State: EMPTY (valid_q=0) / FULL (valid_q=1). Registers: data_q, en_q[NUM_OUT], served_q[NUM_OUT], token_cnt.
- out_valid[i] = valid_q & en_q[i] & ~served_q[i]; out_data = data_q (held stable while FULL).
- fire[i] = out_valid[i] & out_ready[i].
- all_done = valid_q & &(served_q | fire | ~en_q).
- in_ready = ~flush & (~valid_q | all_done).
- load = in_valid & in_ready: data_q<=in_data, en_q<=cfg_en, served_q<=0, valid_q<=1.
- Else if all_done: valid_q<=0, served_q<=0 (EMPTY).
- Else if FULL: served_q<=served_q | fire.
- all_done increments token_cnt by 1 (wrap at 2^CNT_W-1 -> 0), independent of load.
- EMPTY -> FULL on load. FULL -> FULL on load with all_done (back-to-back). FULL -> EMPTY on all_done without load.
- cfg_en changes mid-token are ignored until next load; en_q governs the current token.
- en_q all zero: token completes in the cycle after load (all_done=1, no out_valid asserted); still counted.
- flush: valid_q<=0, served_q<=0, in_ready=0 that cycle, fire ignored, token_cnt not incremented and not cleared; flush wins over load and all_done.
- out_ready for disabled or already-served consumers is don't-care.

## Timing
- Reset: valid_q=0, served_q=0, en_q=0, data_q=0, token_cnt=0 -> out_valid=0, out_data=0, in_ready=1, token_cnt=0.
- Reset mid-token drops the token asynchronously; no output glitch to valid after deassertion.
- Latency: in_valid&in_ready at cycle t -> out_valid at t+1.
- Throughput: 1 token/cycle when all enabled consumers are ready.
- in_ready depends combinationally on out_ready (via fire); no combinational path from in_valid to in_ready or out_valid.
- out_valid[i] once asserted stays asserted with out_data stable until fire[i], all_done, or flush.

## Structure
- Package fanout_pkg: NUM_OUT/DATA_W/CNT_W defaults, state enum {FO_EMPTY, FO_FULL}.
- Single module; no sub-module. State enum explicit even though equivalent to valid_q.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, token_cnt=0; load 0x1ABCD with cfg_en=6'b111111, all out_ready=1 -> out_valid=6'b111111 at t+1, out_data=0x1ABCD, token_cnt=1 next cycle, stream of 8 tokens at full rate -> token_cnt=8 with no bubbles.
- Staggered acceptance: cfg_en=6'b000111, out_ready[0] at t+1, [1] at t+3, [2] at t+5 -> out_valid drops per output after its fire, in_ready=1 only at t+5, each consumer sees token exactly once.
- Mask change mid-token: load with cfg_en=6'b000011, switch to 6'b111100 while FULL -> only outputs 0,1 valid for this token; next token uses 6'b111100.
- cfg_en=0: push 4 tokens -> no out_valid ever, token_cnt=4, in_ready toggles per EMPTY/FULL (one token per 2 cycles max? no: back-to-back, token_cnt rises every cycle).
- Flush with output 0 served, output 1 pending, in_valid=1 -> in_ready=0, next cycle EMPTY, out_valid=0, token_cnt unchanged.
- Async rst_n assert while FULL and token_cnt=0xFFFF wrap: first wrap 0xFFFF->0x0000 on completion; then reset -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fanout_pkg.sv
// fanout_pkg
//   Shared defaults and state encoding for the eager-fork fanout controller.
//   FO_NUM_OUT : default number of downstream consumers
//   FO_DATA_W  : default token width (payload plus control/done bit)
//   FO_CNT_W   : default width of the completed-token counter
//   fo_state_e : buffer occupancy, FO_EMPTY / FO_FULL
package fanout_pkg;

  localparam int unsigned FO_NUM_OUT = 6;
  localparam int unsigned FO_DATA_W  = 17;
  localparam int unsigned FO_CNT_W   = 16;

  typedef enum logic {
    FO_EMPTY = 1'b0,
    FO_FULL  = 1'b1
  } fo_state_e;

endpackage

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl
//   Registered eager fork: one upstream token is held in a single-entry buffer
//   and offered to every enabled consumer. Each consumer accepts on its own
//   schedule; the buffer frees once every enabled consumer has taken it.
//
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_en     : per-consumer enable mask, captured only when a token loads
//   flush      : synchronous drop of the buffered token (wins over everything)
//   in_valid   : producer token valid
//   in_data    : producer token
//   in_ready   : buffer can take a token this cycle
//   out_valid  : per-consumer valid
//   out_data   : buffered token, shared by all consumers
//   out_ready  : per-consumer ready
//   token_cnt  : count of fully delivered tokens, wraps
module fanout_fork_ctrl
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_OUT = FO_NUM_OUT,
  parameter int unsigned DATA_W  = FO_DATA_W,
  parameter int unsigned CNT_W   = FO_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_OUT-1:0] cfg_en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [CNT_W-1:0]  token_cnt
);

  fo_state_e          state_q;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic [NUM_OUT-1:0] en_q;
  logic [NUM_OUT-1:0] served_q;
  logic [NUM_OUT-1:0] fire;
  logic               all_done;
  logic               load;

  assign valid_q   = (state_q == FO_FULL);
  assign out_valid = {NUM_OUT{valid_q}} & en_q & ~served_q;
  assign out_data  = data_q;
  assign fire      = out_valid & out_ready;

  // A consumer counts as finished if it was served earlier, is taking the
  // token now, or was never enabled; an all-zero mask completes immediately.
  assign all_done  = valid_q & (&(served_q | fire | ~en_q));
  assign in_ready  = ~flush & (~valid_q | all_done);
  assign load      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FO_EMPTY;
      data_q    <= '0;
      en_q      <= '0;
      served_q  <= '0;
      token_cnt <= '0;
    end else begin
      if (flush) begin
        state_q  <= FO_EMPTY;
        served_q <= '0;
      end else if (load) begin
        state_q  <= FO_FULL;
        data_q   <= in_data;
        en_q     <= cfg_en;
        served_q <= '0;
      end else if (all_done) begin
        state_q  <= FO_EMPTY;
        served_q <= '0;
      end else if (valid_q) begin
        served_q <= served_q | fire;
      end

      // Completion is counted even when a new token loads in the same cycle.
      if (all_done && !flush) begin
        token_cnt <= token_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
module tb_fanout_fork_ctrl;

  localparam int unsigned NUM_OUT = 6;
  localparam int unsigned DATA_W  = 17;
  localparam int unsigned CNT_W   = 16;

  logic               clk;
  logic               rst_n;
  logic [NUM_OUT-1:0] cfg_en;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic [NUM_OUT-1:0] out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_ready;
  logic [CNT_W-1:0]   token_cnt;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [CNT_W-1:0] exp_cnt;

  // Per-consumer scoreboard of tokens each consumer still has to receive.
  logic [DATA_W-1:0] sb [NUM_OUT][$];

  fanout_fork_ctrl #(
    .NUM_OUT(NUM_OUT),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .token_cnt(token_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pop on each consumer handshake, push on each accepted load.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        for (int i = 0; i < NUM_OUT; i++) sb[i].delete();
      end else begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            n_cmp++;
            if (sb[i].size() == 0) begin
              n_err++;
              $display("FAIL sb_unexpected_fire[%0d]: got data %h, expected no token", i, out_data);
            end else begin
              logic [DATA_W-1:0] e;
              e = sb[i].pop_front();
              if (out_data !== e) begin
                n_err++;
                $display("FAIL sb_data[%0d]: got %h expected %h", i, out_data, e);
              end
            end
          end
        end
        if (in_valid && in_ready) begin
          for (int i = 0; i < NUM_OUT; i++) if (cfg_en[i]) sb[i].push_back(in_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_en = '0; out_ready = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00) begin n_err++; $display("FAIL reset_out_valid: got %h expected 00", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (token_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_token_cnt: got %h expected 0000", token_cnt); end
    n_cmp++; if (out_data !== 17'h00000) begin n_err++; $display("FAIL reset_out_data: got %h expected 00000", out_data); end
    tick(); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00 || in_ready !== 1'b1) begin n_err++; $display("FAIL idle: got valid %h ready %b expected 00 1", out_valid, in_ready); end
    exp_cnt = '0;
  endtask

  task automatic test_basic_stream();
    tick(); cfg_en = 6'h3F; out_ready = 6'h3F; in_valid = 1'b1; in_data = 17'h1ABCD;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_load_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h3F) begin n_err++; $display("FAIL basic_out_valid: got %h expected 3f", out_valid); end
    n_cmp++; if (out_data !== 17'h1ABCD) begin n_err++; $display("FAIL basic_out_data: got %h expected 1abcd", out_data); end
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL basic_cnt_pre: got %h expected %h", token_cnt, exp_cnt); end
    tick(); exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL basic_cnt_post: got %h expected %h", token_cnt, exp_cnt); end
    n_cmp++; if (out_valid !== 6'h00) begin n_err++; $display("FAIL basic_empty: got %h expected 00", out_valid); end
    for (int k = 0; k < 8; k++) begin
      tick(); in_valid = 1'b1; in_data = DATA_W'(k * 32'h1111 + 5);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, in_ready); end
      if (k > 0) begin
        n_cmp++; if (out_valid !== 6'h3F) begin n_err++; $display("FAIL stream_valid[%0d]: got %h expected 3f", k, out_valid); end
        n_cmp++; if (token_cnt !== exp_cnt + CNT_W'(k - 1)) begin n_err++; $display("FAIL stream_cnt[%0d]: got %h expected %h", k, token_cnt, exp_cnt + CNT_W'(k - 1)); end
      end
    end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h3F) begin n_err++; $display("FAIL stream_last_valid: got %h expected 3f", out_valid); end
    tick();
    exp_cnt = exp_cnt + 16'd8;
    @(negedge clk);
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL stream_cnt_final: got %h expected %h", token_cnt, exp_cnt); end
  endtask

  task automatic test_staggered();
    tick(); cfg_en = 6'h07; out_ready = 6'h00; in_valid = 1'b1; in_data = 17'h0F0F0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stag_load_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0; out_ready = 6'b000001;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h07 || in_ready !== 1'b0) begin n_err++; $display("FAIL stag_t1: got valid %h ready %b expected 07 0", out_valid, in_ready); end
    tick(); out_ready = 6'b000000;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h06 || in_ready !== 1'b0) begin n_err++; $display("FAIL stag_t2: got valid %h ready %b expected 06 0", out_valid, in_ready); end
    tick(); out_ready = 6'b000011;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h06 || in_ready !== 1'b0) begin n_err++; $display("FAIL stag_t3: got valid %h ready %b expected 06 0", out_valid, in_ready); end
    tick(); out_ready = 6'b000000;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h04 || out_data !== 17'h0F0F0) begin n_err++; $display("FAIL stag_t4: got valid %h data %h expected 04 0f0f0", out_valid, out_data); end
    tick(); out_ready = 6'b111100;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h04 || in_ready !== 1'b1) begin n_err++; $display("FAIL stag_t5: got valid %h ready %b expected 04 1", out_valid, in_ready); end
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL stag_cnt_pre: got %h expected %h", token_cnt, exp_cnt); end
    tick(); out_ready = 6'b000000; exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00 || token_cnt !== exp_cnt) begin n_err++; $display("FAIL stag_done: got valid %h cnt %h expected 00 %h", out_valid, token_cnt, exp_cnt); end
    for (int i = 0; i < NUM_OUT; i++) begin
      n_cmp++; if (sb[i].size() != 0) begin n_err++; $display("FAIL stag_drain[%0d]: got %0d pending expected 0", i, sb[i].size()); end
    end
  endtask

  task automatic test_mask_change();
    tick(); cfg_en = 6'h03; out_ready = 6'h00; in_valid = 1'b1; in_data = 17'h12345;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mask_load_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0; cfg_en = 6'h3C;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h03) begin n_err++; $display("FAIL mask_hold: got %h expected 03", out_valid); end
    tick(); out_ready = 6'h3F; in_valid = 1'b1; in_data = 17'h05A5A;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h03 || in_ready !== 1'b1) begin n_err++; $display("FAIL mask_b2b: got valid %h ready %b expected 03 1", out_valid, in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h3C || out_data !== 17'h05A5A) begin n_err++; $display("FAIL mask_next: got valid %h data %h expected 3c 05a5a", out_valid, out_data); end
    tick(); out_ready = 6'h00; exp_cnt = exp_cnt + 16'd2;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00 || token_cnt !== exp_cnt) begin n_err++; $display("FAIL mask_done: got valid %h cnt %h expected 00 %h", out_valid, token_cnt, exp_cnt); end
    for (int i = 0; i < NUM_OUT; i++) begin
      n_cmp++; if (sb[i].size() != 0) begin n_err++; $display("FAIL mask_drain[%0d]: got %0d pending expected 0", i, sb[i].size()); end
    end
  endtask

  task automatic test_zero_mask();
    cfg_en = 6'h00; out_ready = 6'h00;
    for (int k = 0; k < 4; k++) begin
      tick(); in_valid = 1'b1; in_data = DATA_W'(32'h100 + k);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 6'h00) begin n_err++; $display("FAIL zero_cycle[%0d]: got ready %b valid %h expected 1 00", k, in_ready, out_valid); end
      if (k > 0) begin
        n_cmp++; if (token_cnt !== exp_cnt + CNT_W'(k - 1)) begin n_err++; $display("FAIL zero_cnt[%0d]: got %h expected %h", k, token_cnt, exp_cnt + CNT_W'(k - 1)); end
      end
    end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00) begin n_err++; $display("FAIL zero_last_valid: got %h expected 00", out_valid); end
    tick(); exp_cnt = exp_cnt + 16'd4;
    @(negedge clk);
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL zero_cnt_final: got %h expected %h", token_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    tick(); cfg_en = 6'h03; out_ready = 6'h00; in_valid = 1'b1; in_data = 17'h1C0DE;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_load_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0; out_ready = 6'b000001;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h03) begin n_err++; $display("FAIL flush_pre: got %h expected 03", out_valid); end
    tick(); out_ready = 6'b000010; flush = 1'b1; in_valid = 1'b1; in_data = 17'h0D00D;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 6'h02) begin n_err++; $display("FAIL flush_cycle: got ready %b valid %h expected 0 02", in_ready, out_valid); end
    tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 6'h00;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_empty: got valid %h ready %b expected 00 1", out_valid, in_ready); end
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL flush_cnt: got %h expected %h", token_cnt, exp_cnt); end
    tick();
    @(negedge clk);
    n_cmp++; if (token_cnt !== exp_cnt || out_valid !== 6'h00) begin n_err++; $display("FAIL flush_settle: got cnt %h valid %h expected %h 00", token_cnt, out_valid, exp_cnt); end
    for (int i = 0; i < NUM_OUT; i++) begin
      n_cmp++; if (sb[i].size() != 0) begin n_err++; $display("FAIL flush_drain[%0d]: got %0d pending expected 0", i, sb[i].size()); end
    end
  endtask

  task automatic test_wrap_reset();
    int unsigned n;
    n = 32'(16'hFFFF - exp_cnt);
    cfg_en = 6'h00; out_ready = 6'h00;
    for (int unsigned k = 0; k < n; k++) begin
      tick(); in_valid = 1'b1; in_data = DATA_W'(k);
    end
    tick(); in_valid = 1'b0;
    tick();
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    n_cmp++; if (token_cnt !== exp_cnt) begin n_err++; $display("FAIL wrap_pre: got %h expected ffff", token_cnt); end
    tick(); cfg_en = 6'h01; in_valid = 1'b1; in_data = 17'h1FFFF;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h01 || token_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_hold: got valid %h cnt %h expected 01 ffff", out_valid, token_cnt); end
    tick(); out_ready = 6'h01;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wrap_done_ready: got %b expected 1", in_ready); end
    tick(); out_ready = 6'h00;
    @(negedge clk);
    n_cmp++; if (token_cnt !== 16'h0000 || out_valid !== 6'h00) begin n_err++; $display("FAIL wrap_zero: got cnt %h valid %h expected 0000 00", token_cnt, out_valid); end
    tick(); cfg_en = 6'h00; in_valid = 1'b1; in_data = 17'h00001;
    tick(); cfg_en = 6'h3F; in_data = 17'h0BEEF;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wrap_b2b_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h3F || token_cnt !== 16'h0001) begin n_err++; $display("FAIL pre_reset: got valid %h cnt %h expected 3f 0001", out_valid, token_cnt); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 6'h00 || in_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_hs: got valid %h ready %b expected 00 1", out_valid, in_ready); end
    n_cmp++; if (token_cnt !== 16'h0000 || out_data !== 17'h00000) begin n_err++; $display("FAIL async_reset_regs: got cnt %h data %h expected 0000 00000", token_cnt, out_data); end
    for (int i = 0; i < NUM_OUT; i++) sb[i].delete();
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00 || in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset: got valid %h ready %b expected 00 1", out_valid, in_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (out_valid !== 6'h00 || token_cnt !== 16'h0000) begin n_err++; $display("FAIL post_reset_idle: got valid %h cnt %h expected 00 0000", out_valid, token_cnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = '0;
    test_reset();
    test_basic_stream();
    test_staggered();
    test_mask_change();
    test_zero_mask();
    test_flush();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
